bcd_mod_counter: RTL and testbench

Parametrised two-digit BCD modulo-N counter: the generalised successor of the team's 4-bit counter, and the basic timekeeping cell of the digital clock. The seconds and minutes stages use MODULO=60, and the hours stage uses MODULO=24. The block adds an up/down count direction, count enable, synchronous preset load with range checking, and a terminal-count carry for cascading stages.

---
 rtl/bcd_mod_counter.sv | 85 ++++++++
 tb/tb_bcd_mod_counter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD modulo-N up/down counter with preset load and cascade carry
module bcd_mod_counter #(
  parameter int MODULO = 60
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  input  logic       UP,
  input  logic       LOAD,
  input  logic [3:0] LOAD_TENS,
  input  logic [3:0] LOAD_ONES,
  output logic [3:0] Q_TENS,
  output logic [3:0] Q_ONES,
  output logic       CARRY,
  output logic       LOAD_ERR
);

  localparam int MAX_TENS_I = (MODULO - 1) / 10;
  localparam int MAX_ONES_I = (MODULO - 1) % 10;
  localparam logic [3:0] MAX_TENS = MAX_TENS_I[3:0];
  localparam logic [3:0] MAX_ONES = MAX_ONES_I[3:0];

  logic       at_max;
  logic       at_zero;
  logic       load_ok;
  logic [3:0] next_tens;
  logic [3:0] next_ones;

  assign at_max  = (Q_TENS == MAX_TENS) && (Q_ONES == MAX_ONES);
  assign at_zero = (Q_TENS == 4'd0) && (Q_ONES == 4'd0);

  // Range check is done digit-wise against the terminal value, no binary conversion.
  assign load_ok = (LOAD_TENS <= 4'd9) && (LOAD_ONES <= 4'd9) &&
                   ((LOAD_TENS < MAX_TENS) ||
                    ((LOAD_TENS == MAX_TENS) && (LOAD_ONES <= MAX_ONES)));

  assign CARRY = EN & ~LOAD & ~RESET & (UP ? at_max : at_zero);

  always_comb begin
    next_tens = Q_TENS;
    next_ones = Q_ONES;
    if (UP) begin
      if (at_max) begin
        next_tens = 4'd0;
        next_ones = 4'd0;
      end else if (Q_ONES == 4'd9) begin
        next_tens = Q_TENS + 4'd1;
        next_ones = 4'd0;
      end else begin
        next_ones = Q_ONES + 4'd1;
      end
    end else begin
      if (at_zero) begin
        next_tens = MAX_TENS;
        next_ones = MAX_ONES;
      end else if (Q_ONES == 4'd0) begin
        next_tens = Q_TENS - 4'd1;
        next_ones = 4'd9;
      end else begin
        next_ones = Q_ONES - 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      Q_TENS   <= 4'd0;
      Q_ONES   <= 4'd0;
      LOAD_ERR <= 1'b0;
    end else if (LOAD) begin
      LOAD_ERR <= ~load_ok;
      if (load_ok) begin
        Q_TENS <= LOAD_TENS;
        Q_ONES <= LOAD_ONES;
      end
    end else begin
      LOAD_ERR <= 1'b0;
      if (EN) begin
        Q_TENS <= next_tens;
        Q_ONES <= next_ones;
      end
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb/tb_bcd_mod_counter.sv - randomized and directed bench for bcd_mod_counter against an arithmetic model
module tb_bcd_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up, load;
  logic [3:0] lt, lo;
  logic [3:0] t60, o60, t24, o24, t100, o100;
  logic       c60, c24, c100, e60, e24, e100;

  logic       crst, cen, cup, cload;
  logic [3:0] slt, slo, mlt, mlo, hlt, hlo;
  logic [3:0] st, so, mt, mo, ht, ho;
  logic       sc, mc, hc, se, me, he;

  int vectors = 0;
  int errors  = 0;
  int v60, v24, v100;
  bit x60, x24, x100;

  bcd_mod_counter #(.MODULO(60)) u60 (
    .CLK(clk), .RESET(rst), .EN(en), .UP(up), .LOAD(load), .LOAD_TENS(lt), .LOAD_ONES(lo),
    .Q_TENS(t60), .Q_ONES(o60), .CARRY(c60), .LOAD_ERR(e60));
  bcd_mod_counter #(.MODULO(24)) u24 (
    .CLK(clk), .RESET(rst), .EN(en), .UP(up), .LOAD(load), .LOAD_TENS(lt), .LOAD_ONES(lo),
    .Q_TENS(t24), .Q_ONES(o24), .CARRY(c24), .LOAD_ERR(e24));
  bcd_mod_counter #(.MODULO(100)) u100 (
    .CLK(clk), .RESET(rst), .EN(en), .UP(up), .LOAD(load), .LOAD_TENS(lt), .LOAD_ONES(lo),
    .Q_TENS(t100), .Q_ONES(o100), .CARRY(c100), .LOAD_ERR(e100));

  bcd_mod_counter #(.MODULO(60)) u_sec (
    .CLK(clk), .RESET(crst), .EN(cen), .UP(cup), .LOAD(cload), .LOAD_TENS(slt), .LOAD_ONES(slo),
    .Q_TENS(st), .Q_ONES(so), .CARRY(sc), .LOAD_ERR(se));
  bcd_mod_counter #(.MODULO(60)) u_min (
    .CLK(clk), .RESET(crst), .EN(sc), .UP(cup), .LOAD(cload), .LOAD_TENS(mlt), .LOAD_ONES(mlo),
    .Q_TENS(mt), .Q_ONES(mo), .CARRY(mc), .LOAD_ERR(me));
  bcd_mod_counter #(.MODULO(24)) u_hr (
    .CLK(clk), .RESET(crst), .EN(mc), .UP(cup), .LOAD(cload), .LOAD_TENS(hlt), .LOAD_ONES(hlo),
    .Q_TENS(ht), .Q_ONES(ho), .CARRY(hc), .LOAD_ERR(he));

  function automatic int val(logic [3:0] t, logic [3:0] o);
    return int'(t) * 10 + int'(o);
  endfunction

  function automatic bit preset_ok(int m);
    return (lt <= 9) && (lo <= 9) && (int'(lt) * 10 + int'(lo) < m);
  endfunction

  function automatic int model_next(int v, int m);
    if (rst) return 0;
    if (load) return preset_ok(m) ? int'(lt) * 10 + int'(lo) : v;
    if (!en) return v;
    return up ? (v + 1) % m : (v + m - 1) % m;
  endfunction

  function automatic bit model_err(int m);
    return !rst && load && !preset_ok(m);
  endfunction

  function automatic bit model_carry(int v, int m);
    return !rst && !load && en && (up ? (v == m - 1) : (v == 0));
  endfunction

  task automatic tick();
    int n60, n24, n100;
    n60  = model_next(v60, 60);
    n24  = model_next(v24, 24);
    n100 = model_next(v100, 100);
    x60  = model_err(60);
    x24  = model_err(24);
    x100 = model_err(100);
    @(posedge clk);
    #1;
    v60  = n60;
    v24  = n24;
    v100 = n100;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1; lt = 4'd1; lo = 4'd1;
    tick();
    tick();
    vectors++;
    if (val(t60, o60) !== 0 || e60 !== 1'b0 || c60 !== 1'b0) begin
      errors++;
      $display("FAIL reset_60: V=%0d err=%b carry=%b expected V=0 err=0 carry=0", val(t60, o60), e60, c60);
    end
    vectors++;
    if (val(t24, o24) !== 0 || val(t100, o100) !== 0 || e24 !== 1'b0 || e100 !== 1'b0) begin
      errors++;
      $display("FAIL reset_24_100: V24=%0d V100=%0d expected 0 0", val(t24, o24), val(t100, o100));
    end
  endtask

  task automatic test_count_up();
    rst = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    for (int i = 0; i < 60; i++) begin
      vectors++;
      if (val(t60, o60) !== i || c60 !== (i == 59)) begin
        errors++;
        $display("FAIL count_up step %0d: V=%0d carry=%b expected V=%0d carry=%b", i, val(t60, o60), c60, i, i == 59);
      end
      tick();
    end
    vectors++;
    if (val(t60, o60) !== 0) begin
      errors++;
      $display("FAIL count_up_wrap: V=%0d expected 0", val(t60, o60));
    end
  endtask

  task automatic test_count_down();
    int exp_seq[5] = '{23, 22, 21, 20, 19};
    load = 1'b1; lt = 4'd0; lo = 4'd0; en = 1'b1;
    tick();
    load = 1'b0; up = 1'b0;
    #1;
    vectors++;
    if (val(t24, o24) !== 0 || c24 !== 1'b1) begin
      errors++;
      $display("FAIL down_pre: V=%0d carry=%b expected V=0 carry=1", val(t24, o24), c24);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (val(t24, o24) !== exp_seq[i] || o24 > 4'd9) begin
        errors++;
        $display("FAIL down_step %0d: tens=%0d ones=%0d expected V=%0d", i, t24, o24, exp_seq[i]);
      end
    end
  endtask

  task automatic test_load();
    en = 1'b0; load = 1'b1; lt = 4'd4; lo = 4'd5;
    tick();
    vectors++;
    if (val(t60, o60) !== 45 || e60 !== 1'b0) begin
      errors++;
      $display("FAIL load_45: V=%0d err=%b expected V=45 err=0", val(t60, o60), e60);
    end
    lt = 4'd6; lo = 4'd0;
    tick();
    vectors++;
    if (val(t60, o60) !== 45 || e60 !== 1'b1) begin
      errors++;
      $display("FAIL load_60_rej: V=%0d err=%b expected V=45 err=1", val(t60, o60), e60);
    end
    load = 1'b0;
    tick();
    vectors++;
    if (e60 !== 1'b0) begin
      errors++;
      $display("FAIL load_err_clear1: err=%b expected 0", e60);
    end
    load = 1'b1; lt = 4'd3; lo = 4'd12;
    tick();
    vectors++;
    if (val(t60, o60) !== 45 || e60 !== 1'b1) begin
      errors++;
      $display("FAIL load_3_12_rej: V=%0d err=%b expected V=45 err=1", val(t60, o60), e60);
    end
    load = 1'b0;
    tick();
    vectors++;
    if (e60 !== 1'b0 || val(t60, o60) !== 45) begin
      errors++;
      $display("FAIL load_err_clear2: V=%0d err=%b expected V=45 err=0", val(t60, o60), e60);
    end
  endtask

  task automatic test_reset_priority();
    load = 1'b1; lt = 4'd3; lo = 4'd7;
    tick();
    rst = 1'b1; load = 1'b1; lt = 4'd1; lo = 4'd1; en = 1'b1; up = 1'b1;
    #1;
    vectors++;
    if (c60 !== 1'b0) begin
      errors++;
      $display("FAIL rst_carry_pre: carry=%b expected 0", c60);
    end
    tick();
    vectors++;
    if (val(t60, o60) !== 0 || e60 !== 1'b0 || c60 !== 1'b0) begin
      errors++;
      $display("FAIL rst_prio: V=%0d err=%b carry=%b expected V=0 err=0 carry=0", val(t60, o60), e60, c60);
    end
    rst = 1'b0; load = 1'b0;
    tick();
    vectors++;
    if (val(t60, o60) !== 1) begin
      errors++;
      $display("FAIL rst_resume: V=%0d expected 1", val(t60, o60));
    end
  endtask

  task automatic test_cascade();
    cload = 1'b1; crst = 1'b0; cen = 1'b1; cup = 1'b1;
    hlt = 4'd2; hlo = 4'd3; mlt = 4'd5; mlo = 4'd9; slt = 4'd5; slo = 4'd8;
    tick();
    cload = 1'b0;
    #1;
    vectors++;
    if (val(ht, ho) !== 23 || val(mt, mo) !== 59 || val(st, so) !== 58 || sc !== 1'b0) begin
      errors++;
      $display("FAIL cascade_preset: %0d:%0d:%0d sc=%b expected 23:59:58 sc=0", val(ht, ho), val(mt, mo), val(st, so), sc);
    end
    tick();
    vectors++;
    if (sc !== 1'b1 || mc !== 1'b1 || hc !== 1'b1) begin
      errors++;
      $display("FAIL cascade_carries: sc=%b mc=%b hc=%b expected 1 1 1", sc, mc, hc);
    end
    tick();
    vectors++;
    if (val(ht, ho) !== 0 || val(mt, mo) !== 0 || val(st, so) !== 0) begin
      errors++;
      $display("FAIL cascade_wrap: %0d:%0d:%0d expected 0:0:0", val(ht, ho), val(mt, mo), val(st, so));
    end
    cen = 1'b0;
  endtask

  task automatic test_mod100();
    load = 1'b1; lt = 4'd9; lo = 4'd8; en = 1'b1; up = 1'b1;
    tick();
    load = 1'b0;
    tick();
    vectors++;
    if (t100 !== 4'd9 || o100 !== 4'd9) begin
      errors++;
      $display("FAIL m100_99: tens=%0d ones=%0d expected 9 9", t100, o100);
    end
    tick();
    vectors++;
    if (val(t100, o100) !== 0) begin
      errors++;
      $display("FAIL m100_wrap: V=%0d expected 0", val(t100, o100));
    end
    up = 1'b0;
    #1;
    vectors++;
    if (c100 !== 1'b1) begin
      errors++;
      $display("FAIL m100_borrow: carry=%b expected 1", c100);
    end
    tick();
    vectors++;
    if (val(t100, o100) !== 99) begin
      errors++;
      $display("FAIL m100_down: V=%0d expected 99", val(t100, o100));
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (c100 !== 1'b0) begin
        errors++;
        $display("FAIL m100_hold_carry %0d: carry=%b expected 0", i, c100);
      end
      tick();
      vectors++;
      if (val(t100, o100) !== 99) begin
        errors++;
        $display("FAIL m100_hold %0d: V=%0d expected 99", i, val(t100, o100));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 19) == 0);
      load = ($urandom_range(0, 5) == 0);
      en   = ($urandom_range(0, 3) != 0);
      up   = $urandom_range(0, 1);
      lt   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      lo   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      #1;
      vectors++;
      if (c60 !== model_carry(v60, 60) || c24 !== model_carry(v24, 24) || c100 !== model_carry(v100, 100)) begin
        errors++;
        $display("FAIL rand_carry %0d: got %b%b%b expected %b%b%b", i, c60, c24, c100,
                 model_carry(v60, 60), model_carry(v24, 24), model_carry(v100, 100));
      end
      tick();
      vectors++;
      if (val(t60, o60) !== v60 || val(t24, o24) !== v24 || val(t100, o100) !== v100 ||
          o60 > 4'd9 || o24 > 4'd9 || o100 > 4'd9) begin
        errors++;
        $display("FAIL rand_value %0d: got %0d/%0d/%0d expected %0d/%0d/%0d", i,
                 val(t60, o60), val(t24, o24), val(t100, o100), v60, v24, v100);
      end
      vectors++;
      if (e60 !== x60 || e24 !== x24 || e100 !== x100) begin
        errors++;
        $display("FAIL rand_err %0d: got %b%b%b expected %b%b%b", i, e60, e24, e100, x60, x24, x100);
      end
    end
  endtask

  initial begin
    v60 = 0; v24 = 0; v100 = 0;
    crst = 1'b1; cen = 1'b0; cup = 1'b1; cload = 1'b0;
    slt = 4'd0; slo = 4'd0; mlt = 4'd0; mlo = 4'd0; hlt = 4'd0; hlo = 4'd0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_reset_priority();
    test_cascade();
    test_mod100();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
